and_unit_scheduler: RTL and testbench
=====================================

// Module: and_unit_scheduler
// PURPOSE
//  Shares one WIDTH-bit bitwise-AND datapath (segunda_and) among N requesters.
//  Round-robin arbitration, one operation in flight, registered result held until the consumer accepts it.
//  Sits between requester front-ends and the shared AND unit.
//  Provides valid/ready handshakes on both sides, plus a completed-operation counter.
// PARAMETERS
//  N      4  number of requesters (2..8)
//  ID_W   2  requester-id width, ceil(log2(N))
//  WIDTH  3  operand/result width; must match segunda_and
//  CNT_W  8  width of completed-operation counter
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  reset      in   1          synchronous, active-high
//  req_valid  in   N          requester i has operands pending
//  req_a      in   N*WIDTH    operand A; requester i at [i*WIDTH +: WIDTH]
//  req_b      in   N*WIDTH    operand B, same packing
//  req_ready  out  N          one-hot accept strobe; combinational
//  rsp_valid  out  1          result available
//  rsp_id     out  ID_W       index of requester owning the result
//  rsp_c      out  WIDTH      a & b of the accepted request
//  rsp_ready  in   1          consumer accepts result
//  busy       out  1          state != IDLE
//  op_count   out  CNT_W      completed responses, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset values (takes effect on any clk edge with reset=1; overrides all else):
//   - state=IDLE, ptr=0, op_count=0, rsp_valid=0, rsp_id=0, rsp_c=0, operand regs=0.
//   - req_ready=0 while reset=1.
//   - Reset mid-operation discards the in-flight request silently; no response is produced.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//    - If any req_valid: grant k = first set bit searching ptr, ptr+1, ... modulo N.
//    - req_ready[k]=1 that cycle; capture req_a/req_b slice k and k into op regs.
//    - ptr <= (k+1) mod N; next state EXEC.
//    - No valid: stay in IDLE, req_ready=0.
//   EXEC: rsp_c <= segunda_and(op_a, op_b); rsp_id <= k; rsp_valid <= 1; -> RESP.
//   RESP:
//    - Hold rsp_valid/rsp_id/rsp_c stable until rsp_valid&&rsp_ready.
//    - On that edge: rsp_valid <= 0, op_count <= op_count+1 (wraps), -> IDLE.
//  Latency: accept at cycle t; rsp_valid high from t+2. If rsp_ready is already high, handshake completes at t+2.
//   - Next accept no earlier than t+3. Peak throughput: 1 op / 3 cycles.
//  req_ready is asserted only in IDLE and is never asserted for a requester whose req_valid=0.
//  Requesters hold valid and operands until ready. Dropping valid before ready is legal and simply loses priority.
//  rsp_ready while rsp_valid=0 is ignored.
//  A request arriving during EXEC/RESP waits; fairness: a waiting requester is served within N grants.
//  Unused ptr encodings (N not a power of 2) never occur; ptr wrap uses explicit compare to N-1.
// STRUCTURE
//  Shared header and_sched_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
//   - default N/WIDTH constants.
//  Sub-module rr_arbiter (N, ID_W):
//   - inputs req[N], ptr;
//   - outputs grant one-hot, grant_id, any.
//   - Purely combinational.
//  Datapath: one instance of the existing segunda_and on registered operands.
// TESTING
//  1. reset=1 two cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, op_count=0, busy=0.
//  2. Single req: req0 a=3'b101 b=3'b110, rsp_ready=1 -> req_ready=4'b0001 at t; rsp_valid, rsp_id=0, rsp_c=3'b100 at t+2; op_count=1.
//  3. All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one grant per 3 cycles.
//  4. Backpressure: rsp_ready=0 for 5 cycles with a=3'b111 b=3'b011 -> rsp_c=3'b011 held stable; no new req_ready until the handshake.
//  5. Reset asserted in EXEC -> no response ever appears; next grant goes to requester 0.
//  6. op_count at 8'hFF then one completion -> 8'h00.

Source files
------------

// File: rtl/and_unit_scheduler_pkg.sv
// Shared definitions for the AND-unit scheduler: state type and default sizing.
package and_unit_scheduler_pkg;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_ID_W  = 2;
  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/and_unit_scheduler_if.sv
// Requester/consumer bus of the AND-unit scheduler; slave side is the scheduler.
interface and_unit_scheduler_if
  import and_unit_scheduler_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned ID_W  = DEF_ID_W,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [WIDTH-1:0]   rsp_c;
  logic               rsp_ready;
  logic               busy;
  logic [CNT_W-1:0]   op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, busy, op_count
  );
endinterface

// File: rtl/and_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);
  always_comb begin
    int unsigned s;
    logic [ID_W-1:0] idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    s        = 0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      idx = ID_W'(s);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end
endmodule

// File: rtl/segunda_and.sv
// Shared WIDTH-bit bitwise-AND datapath.
module segunda_and #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);
  assign c = a & b;
endmodule

// File: rtl/and_unit_scheduler.sv
// Round-robin scheduler sharing one AND unit among N requesters, one op in flight.
module and_unit_scheduler
  import and_unit_scheduler_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned ID_W  = DEF_ID_W,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  and_unit_scheduler_if.slave  bus
);
  state_t           r_state, w_next;
  logic [ID_W-1:0]  r_ptr;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic [ID_W-1:0]  r_op_id;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_c;
  logic [CNT_W-1:0] r_op_count;

  logic [N-1:0]     w_grant;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_any;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_a, w_sel_b, w_and_c;

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
    .req      (bus.req_valid),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .grant_id (w_grant_id),
    .any      (w_any)
  );

  segunda_and #(.WIDTH(WIDTH)) u_and (
    .a (r_op_a),
    .b (r_op_b),
    .c (w_and_c)
  );

  assign w_accept      = (r_state == ST_IDLE) && w_any && !reset;
  assign bus.req_ready = w_accept ? w_grant : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.op_count  = r_op_count;

  // One-hot grant drives an AND-OR mux, avoiding a variable part-select.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_sel_a = bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (r_rsp_valid && bus.rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_id     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_c     <= '0;
      r_op_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a  <= w_sel_a;
        r_op_b  <= w_sel_b;
        r_op_id <= w_grant_id;
        r_ptr   <= (w_grant_id == ID_W'(N-1)) ? '0 : w_grant_id + ID_W'(1);
      end
      if (r_state == ST_EXEC) begin
        r_rsp_c     <= w_and_c;
        r_rsp_id    <= r_op_id;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == ST_RESP && r_rsp_valid && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_and_unit_scheduler.sv
// Randomized scoreboard bench for and_unit_scheduler with a timeline-level reference model.
module tb_and_unit_scheduler;
  localparam int unsigned N = 4, ID_W = 2, W = 3, CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  and_unit_scheduler_if #(.N(N), .ID_W(ID_W), .WIDTH(W), .CNT_W(CW)) bus ();

  and_unit_scheduler #(.N(N), .ID_W(ID_W), .WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int unsigned id;
    int unsigned c;
  } exp_t;

  int checks = 0;
  int failures = 0;

  // stimulus state
  logic [N-1:0] v;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];

  // reference model (written only by the monitor)
  exp_t        q[$];
  int unsigned m_ptr = 0;
  int unsigned m_count = 0;
  bit          m_free = 1'b1;
  bit          m_prev_reset = 1'b0;
  int          m_cyc = 0;
  int          m_resp_from = 0;
  logic [N-1:0] g_last_grant = '0;
  int          n_grants = 0;
  int unsigned grant_log[$];
  int          grant_cyc[$];
  logic [N-1:0] exp_rdy;
  int unsigned mk;
  bit          found;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, derives expectations from the protocol rules.
  always @(negedge clk) begin
    m_cyc++;
    g_last_grant = '0;
    if (reset) begin
      chk("ready_in_reset", bus.req_ready, 0);
      m_free = 1'b1;
      m_ptr = 0;
      m_count = 0;
      q.delete();
      m_prev_reset = 1'b1;
    end else begin
      if (m_prev_reset) begin
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_op_count", bus.op_count, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_c", bus.rsp_c, 0);
      end
      m_prev_reset = 1'b0;
      chk("op_count", bus.op_count, m_count);
      chk("busy", bus.busy, m_free ? 0 : 1);
      if (m_free) begin
        exp_rdy = '0;
        found = 1'b0;
        mk = 0;
        for (int unsigned off = 0; off < N; off++) begin
          if (!found && bus.req_valid[(m_ptr + off) % N]) begin
            found = 1'b1;
            mk = (m_ptr + off) % N;
          end
        end
        if (found) exp_rdy[mk] = 1'b1;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("rsp_valid_idle", bus.rsp_valid, 0);
        if (found) begin
          q.push_back('{id: mk,
                        c: bus.req_a[mk*W +: W] & bus.req_b[mk*W +: W]});
          m_ptr = (mk + 1) % N;
          m_free = 1'b0;
          m_resp_from = m_cyc + 2;
          g_last_grant = exp_rdy;
          n_grants++;
          grant_log.push_back(mk);
          grant_cyc.push_back(m_cyc);
        end
      end else begin
        chk("req_ready_busy", bus.req_ready, 0);
        chk("rsp_valid", bus.rsp_valid, (m_cyc >= m_resp_from) ? 1 : 0);
        if (m_cyc >= m_resp_from) begin
          if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
          end else begin
            chk("rsp_id", bus.rsp_id, q[0].id);
            chk("rsp_c", bus.rsp_c, q[0].c);
            if (bus.rsp_ready) begin
              void'(q.pop_front());
              m_count = (m_count + 1) % 256;
              m_free = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = a[i];
      bus.req_b[i*W +: W] = b[i];
    end
    bus.req_valid = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string nm, input int maxc);
    int start;
    bit ok;
    start = n_grants;
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      tick();
      if (n_grants != start) ok = 1'b1;
    end
    if (!ok) chk(nm, 0, 1);
  endtask

  task automatic rand_step();
    for (int i = 0; i < N; i++) begin
      if (v[i] && g_last_grant[i]) begin
        v[i] = 1'($urandom_range(0, 1));
        a[i] = W'($urandom);
        b[i] = W'($urandom);
      end else if (!v[i]) begin
        if ($urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          a[i] = W'($urandom);
          b[i] = W'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        v[i] = 1'b0;
      end
    end
    drive();
  endtask

  initial begin
    int unsigned exp_order[5];
    // reset with every requester pending
    v = '1;
    for (int i = 0; i < N; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
    end
    bus.rsp_ready = 1'b1;
    drive();
    tick();
    tick();

    // single request from requester 0
    reset = 1'b0;
    v = 4'b0001;
    a[0] = 3'b101;
    b[0] = 3'b110;
    drive();
    wait_grant("timeout_single", 10);
    v = '0;
    drive();
    repeat (4) tick();

    // all requesters continuously valid, starting from ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    v = '1;
    drive();
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (g_last_grant[i]) begin
          a[i] = W'($urandom);
          b[i] = W'($urandom);
        end
      drive();
    end
    exp_order = '{0, 1, 2, 3, 0};
    if (grant_log.size() < 5) chk("rr_grant_count", grant_log.size(), 5);
    else
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", grant_log[i], exp_order[i]);
        if (i > 0) chk("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
      end

    // backpressure on the response side
    v = '0;
    drive();
    repeat (4) tick();
    bus.rsp_ready = 1'b0;
    v = 4'b0100;
    a[2] = 3'b111;
    b[2] = 3'b011;
    drive();
    wait_grant("timeout_bp", 10);
    v = 4'b0010;
    drive();
    repeat (7) tick();
    bus.rsp_ready = 1'b1;
    v = '0;
    drive();
    repeat (3) tick();

    // reset while the accepted request is in EXEC
    v = 4'b0010;
    drive();
    wait_grant("timeout_rst_exec", 10);
    reset = 1'b1;
    v = '0;
    drive();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    grant_log.delete();
    v = '1;
    drive();
    wait_grant("timeout_after_rst", 10);
    if (grant_log.size() == 0) chk("post_reset_grant_seen", 0, 1);
    else chk("post_reset_grant", grant_log[0], 0);

    // randomized traffic, long enough for op_count to wrap past 8'hFF
    for (int c = 0; c < 1300; c++) begin
      tick();
      bus.rsp_ready = ($urandom_range(0, 7) != 0);
      rand_step();
    end
    bus.rsp_ready = 1'b1;
    v = '0;
    drive();
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
